// File: rtl/pl_pkg.sv
// pl_pkg -- shared definitions for the pipeline hazard unit.
//   pl_state_t      : memory-wait FSM states (RUN, MEM_WAIT)
//   FWD_RF/MEM/WB   : EX operand forward-select encodings
//   RESULTSRC_LOAD  : ResultSrc value that marks a load in EX
//   WAIT_LIMIT      : memory-wait count at which mem_timeout latches
package pl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

    localparam logic [7:0] WAIT_LIMIT = 8'd255;

endpackage

// File: rtl/pl_fwd_sel.sv
// pl_fwd_sel -- register comparators for one decode-stage source operand.
//   rs, use_rs                : source register and its read-enable
//   ex_rd/ex_regwrite         : EX-stage producer
//   mem_rd/mem_regwrite       : MEM-stage producer
//   wb_rd/wb_regwrite         : WB-stage producer
//   fwd                       : forward select (MEM over WB over register file)
//   ex_hit, mem_hit           : operand is actually read and an EX / MEM
//                               producer writes it (drives stall decisions)
// Register x0 never matches.
module pl_fwd_sel
    import pl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       use_rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_regwrite,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwrite,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwrite,
    output logic [1:0] fwd,
    output logic       ex_hit,
    output logic       mem_hit
);

    logic mem_match;
    logic wb_match;

    assign mem_match = mem_regwrite && (mem_rd != 5'd0) && (mem_rd == rs);
    assign wb_match  = wb_regwrite  && (wb_rd  != 5'd0) && (wb_rd  == rs);

    assign ex_hit  = use_rs && ex_regwrite && (ex_rd != 5'd0) && (ex_rd == rs);
    assign mem_hit = use_rs && mem_match;

    // The youngest producer (MEM) holds the most recent value.
    always_comb begin
        fwd = FWD_RF;
        if (mem_match) begin
            fwd = FWD_MEM;
        end else if (wb_match) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pl_hazard_unit.sv
// pl_hazard_unit -- stall / flush / forward control for a 5-stage pipeline.
//   clk, rst                  : clock, synchronous active-high reset
//   id_rs1/2, id_use_rs1/2    : decode-stage sources and their read-enables
//   ex/mem/wb_rd, *_regwrite  : destination and RegWrite of EX, MEM, WB
//   ex_resultsrc              : EX ResultSrc (RESULTSRC_LOAD marks a load)
//   ex_pcsrc                  : taken branch/jump resolving in EX
//   dmem_req, dmem_ready      : MEM-stage request and memory completion
//   stall_f/d/e/m             : hold the matching pipeline register
//   flush_d/e/w               : load a bubble into the matching register
//   fwd_a, fwd_b              : EX operand select (FWD_RF/FWD_MEM/FWD_WB)
//   mem_timeout               : sticky, set after WAIT_LIMIT wait cycles
//   stall_cycles              : saturating count of cycles with stall_d high
// Build option: define PL_HAZARD_FORWARD_EN to build operand forwarding;
// without it fwd_a/fwd_b stay at FWD_RF and any RAW against an EX or MEM
// producer stalls decode until the producer reaches WB.
module pl_hazard_unit
    import pl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  mem_rd,
    input  logic [4:0]  wb_rd,
    input  logic        ex_regwrite,
    input  logic        mem_regwrite,
    input  logic        wb_regwrite,
    input  logic [1:0]  ex_resultsrc,
    input  logic        ex_pcsrc,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        flush_d,
    output logic        flush_e,
    output logic        flush_w,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    pl_state_t  state;
    pl_state_t  state_nxt;
    logic [7:0] wait_cnt;

    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       ex_hit_a;
    logic       ex_hit_b;
    logic       mem_hit_a;
    logic       mem_hit_b;
    logic       load_use;
    logic       data_hazard;
    logic       freeze;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       sig_unused;

    pl_fwd_sel u_sel_a (
        .rs           (id_rs1),
        .use_rs       (id_use_rs1),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (sel_a),
        .ex_hit       (ex_hit_a),
        .mem_hit      (mem_hit_a)
    );

    pl_fwd_sel u_sel_b (
        .rs           (id_rs2),
        .use_rs       (id_use_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd          (sel_b),
        .ex_hit       (ex_hit_b),
        .mem_hit      (mem_hit_b)
    );

    assign load_use = (ex_resultsrc == RESULTSRC_LOAD) && (ex_hit_a || ex_hit_b);

`ifdef PL_HAZARD_FORWARD_EN
    // Only a load cannot be bypassed in time; WB is covered by the
    // write-first register file.
    assign data_hazard = load_use;
    assign fwd_a_sel   = sel_a;
    assign fwd_b_sel   = sel_b;
    assign sig_unused  = mem_hit_a ^ mem_hit_b;
`else
    // No bypass network: wait until every EX/MEM producer has reached WB.
    assign data_hazard = load_use || ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
    assign fwd_a_sel   = FWD_RF;
    assign fwd_b_sel   = FWD_RF;
    assign sig_unused  = ^{sel_a, sel_b};
`endif

    // The cycle that issues a request already freezes if memory is not ready.
    assign freeze = ((state == MEM_WAIT) || dmem_req) && !dmem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (dmem_req && !dmem_ready) state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready)              state_nxt = RUN;
            default:                               state_nxt = RUN;
        endcase
    end

    // Priority: reset, memory freeze, control-flow flush, data hazard.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        fwd_a   = FWD_RF;
        fwd_b   = FWD_RF;
        if (!rst) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            if (freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (ex_pcsrc) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (data_hazard) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == MEM_WAIT) begin
                if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + 8'd1;
                end
                // Latch together with the count reaching the limit.
                if (wait_cnt == WAIT_LIMIT - 8'd1) begin
                    mem_timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= 8'd0;
            end
            if (stall_d && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule
